// File: rtl/pkt_cap_pkg.sv
// Shared types and record address math for the packet capture write and read paths.
package pkt_cap_pkg;

  localparam int HDR_WORDS = 4;

  localparam logic [15:0] HDR_OFF_SEC  = 16'd0;
  localparam logic [15:0] HDR_OFF_NSEC = 16'd1;
  localparam logic [15:0] HDR_OFF_LEN  = 16'd2;
  localparam logic [15:0] HDR_OFF_LEN2 = 16'd3;

  typedef enum logic [3:0] {
    PR_IDLE,
    PR_HDR_REQ,
    PR_HDR_RX,
    PR_CHECK,
    PR_PL_WAIT,
    PR_PL_REQ,
    PR_PL_RX,
    PR_DONE,
    PR_ERR
  } pkt_rd_state_t;

  function automatic logic [9:0] rec_pl_words(input logic [15:0] len);
    return 10'(({1'b0, len} + 17'd3) >> 2);
  endfunction

  // Header plus payload rounded up to whole words; wraps modulo 2^32.
  function automatic logic [31:0] rec_next_addr(input logic [31:0] base, input logic [15:0] len);
    return base + 32'(HDR_WORDS * 4) + {15'd0, ({1'b0, len} + 17'd3) & 17'h1FFFC};
  endfunction

endpackage

// File: rtl/pkt_rd_ctrl_if.sv
// Avalon-MM burst read bus between the record reader and memory.
interface pkt_rd_ctrl_if;
  logic [31:0] address;
  logic        read;
  logic [15:0] burstcount;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/pkt_rd_ctrl_avmm_burst_rd.sv
// Issues one Avalon-MM read burst; request held stable under waitrequest, then beats counted.
// Beat valid and burst done follow readdatavalid combinationally; only one burst in flight.
module avmm_burst_rd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [15:0] start_cnt,
  output logic        accepted,
  output logic        beat_vld,
  output logic        burst_done,
  output logic [15:0] beat_idx,
  pkt_rd_ctrl_if.master bus
);

  typedef enum logic [1:0] {B_IDLE, B_REQ, B_RX} burst_state_t;

  burst_state_t st;

  assign accepted   = bus.read && !bus.waitrequest;
  assign beat_vld   = (st == B_RX) && bus.readdatavalid;
  assign burst_done = beat_vld && (beat_idx == bus.burstcount - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st             <= B_IDLE;
      bus.read       <= 1'b0;
      bus.address    <= 32'd0;
      bus.burstcount <= 16'd0;
      beat_idx       <= 16'd0;
    end else begin
      case (st)
        B_IDLE: if (start) begin
          bus.read       <= 1'b1;
          bus.address    <= start_addr;
          bus.burstcount <= start_cnt;
          beat_idx       <= 16'd0;
          st             <= B_REQ;
        end
        B_REQ: if (!bus.waitrequest) begin
          bus.read <= 1'b0;
          st       <= B_RX;
        end
        B_RX: if (bus.readdatavalid) begin
          beat_idx <= beat_idx + 16'd1;
          if (burst_done) st <= B_IDLE;
        end
        default: st <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pkt_rd_ctrl.sv
// Reads one packet record over Avalon-MM: header to status outputs, payload to the export FIFO
// one cycle after readdatavalid; bursts wait for FIFO room. Option PKT_RD_LEN_CHECK_EN checks len==len2.
module pkt_rd_ctrl
  import pkt_cap_pkg::*;
#(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int MAX_LEN    = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_ctrl,
  input  logic [31:0] read_address,
  output logic        rd_ctrl_rdy,
  output logic [31:0] next_address,
  output logic        error,
  output logic [31:0] rec_seconds,
  output logic [31:0] rec_nanoseconds,
  output logic [15:0] rec_len,
  output logic [31:0] fifo_in,
  output logic        wr_to_fifo,
  output logic        fifo_last,
  output logic [1:0]  last_bytes,
  input  logic [8:0]  usedw,
  pkt_rd_ctrl_if.master avm
);

  pkt_rd_state_t state;
  logic [31:0]   base, pl_addr, len_word;
  logic [9:0]    remaining, burst_n, n_words;
`ifdef PKT_RD_LEN_CHECK_EN
  logic [31:0]   len2_word;
`endif
  logic          go;
  logic [31:0]   go_addr;
  logic [15:0]   go_cnt;
  logic          accepted, beat_vld, burst_done;
  logic [15:0]   beat_idx;
  logic [11:0]   fill_need;
  logic          space_ok;

  assign rec_len = len_word[15:0];
  assign n_words = (remaining > 10'(MAX_BURST)) ? 10'(MAX_BURST) : remaining;

  // The word still in the output register has not reached usedw yet.
  assign fill_need = 12'(usedw) + 12'(wr_to_fifo) + 12'(n_words);
  assign space_ok  = fill_need <= 12'(FIFO_DEPTH);

  always_comb begin
    go      = 1'b0;
    go_addr = pl_addr;
    go_cnt  = {6'd0, n_words};
    if (state == PR_IDLE && rd_ctrl) begin
      go      = 1'b1;
      go_addr = read_address;
      go_cnt  = 16'(HDR_WORDS);
    end else if (state == PR_PL_WAIT && space_ok) begin
      go = 1'b1;
    end
  end

  avmm_burst_rd u_burst (
    .clk        (clk),
    .reset      (reset),
    .start      (go),
    .start_addr (go_addr),
    .start_cnt  (go_cnt),
    .accepted   (accepted),
    .beat_vld   (beat_vld),
    .burst_done (burst_done),
    .beat_idx   (beat_idx),
    .bus        (avm)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= PR_IDLE;
      base            <= 32'd0;
      pl_addr         <= 32'd0;
      len_word        <= 32'd0;
`ifdef PKT_RD_LEN_CHECK_EN
      len2_word       <= 32'd0;
`endif
      remaining       <= 10'd0;
      burst_n         <= 10'd0;
      rd_ctrl_rdy     <= 1'b0;
      next_address    <= 32'd0;
      error           <= 1'b0;
      rec_seconds     <= 32'd0;
      rec_nanoseconds <= 32'd0;
      fifo_in         <= 32'd0;
      wr_to_fifo      <= 1'b0;
      fifo_last       <= 1'b0;
      last_bytes      <= 2'd0;
    end else begin
      rd_ctrl_rdy <= 1'b0;
      wr_to_fifo  <= 1'b0;
      fifo_last   <= 1'b0;
      last_bytes  <= 2'd0;
      case (state)
        PR_IDLE: if (rd_ctrl) begin
          base  <= read_address;
          error <= 1'b0;
          state <= PR_HDR_REQ;
        end
        PR_HDR_REQ: if (accepted) state <= PR_HDR_RX;
        PR_HDR_RX: if (beat_vld) begin
          case (beat_idx)
            HDR_OFF_SEC:  rec_seconds     <= avm.readdata;
            HDR_OFF_NSEC: rec_nanoseconds <= avm.readdata;
            HDR_OFF_LEN:  len_word        <= avm.readdata;
`ifdef PKT_RD_LEN_CHECK_EN
            HDR_OFF_LEN2: len2_word       <= avm.readdata;
`endif
            default: ;
          endcase
          if (burst_done) state <= PR_CHECK;
        end
        PR_CHECK: begin
          remaining <= rec_pl_words(len_word[15:0]);
          pl_addr   <= base + 32'(HDR_WORDS * 4);
          if (len_word > 32'(MAX_LEN)
`ifdef PKT_RD_LEN_CHECK_EN
              || len_word != len2_word
`endif
             ) begin
            error        <= 1'b1;
            rd_ctrl_rdy  <= 1'b1;
            next_address <= base + 32'(HDR_WORDS * 4);
            state        <= PR_ERR;
          end else if (len_word == 32'd0) begin
            rd_ctrl_rdy  <= 1'b1;
            next_address <= base + 32'(HDR_WORDS * 4);
            state        <= PR_DONE;
          end else begin
            state <= PR_PL_WAIT;
          end
        end
        PR_PL_WAIT: if (space_ok) begin
          burst_n <= n_words;
          state   <= PR_PL_REQ;
        end
        PR_PL_REQ: if (accepted) state <= PR_PL_RX;
        PR_PL_RX: if (beat_vld) begin
          wr_to_fifo <= 1'b1;
          fifo_in    <= avm.readdata;
          fifo_last  <= (remaining == 10'd1);
          last_bytes <= (remaining == 10'd1) ? len_word[1:0] : 2'd0;
          if (remaining != 10'd0) remaining <= remaining - 10'd1;
          if (burst_done) begin
            pl_addr <= pl_addr + {20'd0, burst_n, 2'b00};
            if (remaining == 10'd1) begin
              rd_ctrl_rdy  <= 1'b1;
              next_address <= rec_next_addr(base, len_word[15:0]);
              state        <= PR_DONE;
            end else begin
              state <= PR_PL_WAIT;
            end
          end
        end
        PR_DONE: state <= PR_IDLE;
        PR_ERR:  state <= PR_IDLE;
        default: state <= PR_IDLE;
      endcase
    end
  end

endmodule
